// File: rtl/banked_mem_pkg.sv
// -----------------------------------------------------------------------------
// banked_mem_pkg
// Shared configuration, types and address-decode helpers for banked_mem.
//
// Configuration constants:
//   NPORT  number of requester ports
//   NBANK  number of word-interleaved banks (power of 2)
//   DW     data word width
//   AW     word address width; the low BANK_BITS bits select the bank
//
// Optional feature macro: BANKED_MEM_PARITY_EN
//   When defined, each stored word carries one extra even-parity bit (MW = DW+1).
// -----------------------------------------------------------------------------
package banked_mem_pkg;

    localparam int NPORT     = 6;
    localparam int NBANK     = 4;
    localparam int DW        = 8;
    localparam int AW        = 8;

    localparam int BANK_BITS = $clog2(NBANK);
    localparam int ROW_BITS  = AW - BANK_BITS;
    localparam int DEPTH     = 2 ** ROW_BITS;
    localparam int PORT_BITS = (NPORT > 1) ? $clog2(NPORT) : 1;

`ifdef BANKED_MEM_PARITY_EN
    localparam int MW = DW + 1;
`else
    localparam int MW = DW;
`endif

    typedef logic [PORT_BITS-1:0] port_idx_t;
    typedef logic [AW-1:0]        addr_t;
    typedef logic [BANK_BITS-1:0] bank_t;
    typedef logic [ROW_BITS-1:0]  row_t;
    typedef logic [DW-1:0]        data_t;
    typedef logic [MW-1:0]        word_t;

    function automatic bank_t bank_of(input addr_t a);
        return a[BANK_BITS-1:0];
    endfunction

    function automatic row_t row_of(input addr_t a);
        return a[AW-1:BANK_BITS];
    endfunction

    // Even parity bit: makes the total number of ones (data + bit) even.
    function automatic logic parity_f(input data_t d);
        return ^d;
    endfunction

endpackage

// File: rtl/banked_mem_if.sv
// -----------------------------------------------------------------------------
// banked_mem_if
// Request/response bus between NPORT requesters and banked_mem.
//
// Handshake: a request on port p transfers on a rising edge where
// req_valid[p] & req_ready[p]. The requester holds req_we/req_addr/req_wdata
// stable until accepted; req_ready[p] is never 1 while req_valid[p] is 0.
// A read returns rsp_valid[p]=1 with rsp_rdata/rsp_perr exactly one cycle
// after acceptance; there is no backpressure on responses.
//
// Signals:
//   req_valid  NPORT     request present
//   req_we     NPORT     1 = write, 0 = read
//   req_addr   NPORT*AW  port p at [AW*p +: AW]
//   req_wdata  NPORT*DW  port p at [DW*p +: DW]
//   req_ready  NPORT     request accepted this cycle (combinational)
//   rsp_valid  NPORT     read data valid (registered)
//   rsp_rdata  NPORT*DW  read data, port p at [DW*p +: DW] (registered)
//   rsp_perr   NPORT     parity error on returned word (registered)
// Modports: master (requester side), slave (memory side).
// -----------------------------------------------------------------------------
interface banked_mem_if;
    import banked_mem_pkg::*;

    logic [NPORT-1:0]    req_valid;
    logic [NPORT-1:0]    req_we;
    logic [NPORT*AW-1:0] req_addr;
    logic [NPORT*DW-1:0] req_wdata;
    logic [NPORT-1:0]    req_ready;
    logic [NPORT-1:0]    rsp_valid;
    logic [NPORT*DW-1:0] rsp_rdata;
    logic [NPORT-1:0]    rsp_perr;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_perr
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_perr
    );
endinterface

// File: rtl/banked_mem_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter over N requesters.
//
// Ports:
//   i_req       N    request vector
//   i_ptr       PW   port with highest priority this cycle
//   o_gnt       N    one-hot grant (all zero when no request)
//   o_next_ptr  PW   pointer for the next cycle: winner+1 (wrapping N-1 -> 0),
//                    or i_ptr unchanged when nothing is granted
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [PW-1:0] o_next_ptr
);

    // Priority distance of port p from the pointer is (p - ptr) mod N;
    // the requesting port with the smallest distance wins.
    int w_best_d;
    int w_best_p;
    int w_d;

    always_comb begin
        w_best_d = N;
        w_best_p = 0;
        w_d      = 0;
        for (int p = 0; p < N; p++) begin
            w_d = p - int'(i_ptr);
            if (w_d < 0) begin
                w_d = w_d + N;
            end
            if (i_req[p] && (w_d < w_best_d)) begin
                w_best_d = w_d;
                w_best_p = p;
            end
        end
    end

    always_comb begin
        o_gnt      = '0;
        o_next_ptr = i_ptr;
        for (int p = 0; p < N; p++) begin
            o_gnt[p] = (w_best_d < N) && (w_best_p == p);
        end
        if (w_best_d < N) begin
            o_next_ptr = (w_best_p == N - 1) ? '0 : PW'(w_best_p + 1);
        end
    end

endmodule

// File: rtl/banked_mem.sv
// -----------------------------------------------------------------------------
// banked_mem
// NPORT requesters share NBANK word-interleaved single-port banks. Each bank
// has its own round-robin arbiter and serves at most one request per cycle;
// banks operate independently. Writes update the bank row on the accepting
// edge; reads return registered data one cycle after acceptance.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous reset, active-high (clears arbiter pointers and
//              response registers; memory contents are kept)
//   bus        banked_mem_if.slave request/response bus
//   o_dbg_ptr  NBANK*PORT_BITS arbiter pointer of bank b at [PORT_BITS*b +: PORT_BITS]
//
// Optional feature macro: BANKED_MEM_PARITY_EN
//   Defined: banks store an even-parity bit alongside each word and rsp_perr
//   reports stored-parity vs recomputed-parity disagreement with rsp_valid.
//   Undefined: banks are DW wide and rsp_perr is constant 0.
// -----------------------------------------------------------------------------
module banked_mem
    import banked_mem_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    banked_mem_if.slave                bus,
    output logic [NBANK*PORT_BITS-1:0] o_dbg_ptr
);

    addr_t            w_addr      [NPORT];
    data_t            w_wdata     [NPORT];
    bank_t            w_bank      [NPORT];
    row_t             w_row       [NPORT];
    word_t            w_port_word [NPORT];
    logic [NPORT-1:0] w_bank_req  [NBANK];
    logic [NPORT-1:0] w_gnt       [NBANK];
    word_t            w_bank_rdata[NBANK];
    logic [NPORT-1:0] w_ready;
    logic [NPORT-1:0] w_rd_acc;

    logic [NPORT-1:0]    r_rsp_valid;
    logic [NPORT*DW-1:0] r_rsp_rdata;

    // Per-port address decode.
    always_comb begin
        for (int p = 0; p < NPORT; p++) begin
            w_addr[p]  = bus.req_addr[AW*p +: AW];
            w_wdata[p] = bus.req_wdata[DW*p +: DW];
            w_bank[p]  = bank_of(w_addr[p]);
            w_row[p]   = row_of(w_addr[p]);
        end
    end

    // Requests are masked during reset so nothing is accepted and no bank is written.
    always_comb begin
        for (int b = 0; b < NBANK; b++) begin
            for (int p = 0; p < NPORT; p++) begin
                w_bank_req[b][p] = bus.req_valid[p] & ~rst & (w_bank[p] == bank_t'(b));
            end
        end
    end

    for (genvar b = 0; b < NBANK; b++) begin : gen_bank
        port_idx_t r_ptr;
        port_idx_t w_next_ptr;
        word_t     r_mem [DEPTH];
        row_t      w_sel_row;
        logic      w_sel_we;
        data_t     w_sel_wdata;
        word_t     w_wr_word;
        logic      w_any;

        rr_arbiter #(
            .N  (NPORT),
            .PW (PORT_BITS)
        ) u_arb (
            .i_req      (w_bank_req[b]),
            .i_ptr      (r_ptr),
            .o_gnt      (w_gnt[b]),
            .o_next_ptr (w_next_ptr)
        );

        assign w_any = |w_gnt[b];

        // AND-OR mux of the granted port's request fields.
        always_comb begin
            w_sel_row   = '0;
            w_sel_we    = 1'b0;
            w_sel_wdata = '0;
            for (int p = 0; p < NPORT; p++) begin
                if (w_gnt[b][p]) begin
                    w_sel_row   = w_row[p];
                    w_sel_we    = bus.req_we[p];
                    w_sel_wdata = w_wdata[p];
                end
            end
        end

`ifdef BANKED_MEM_PARITY_EN
        assign w_wr_word = {parity_f(w_sel_wdata), w_sel_wdata};
`else
        assign w_wr_word = w_sel_wdata;
`endif

        always_ff @(posedge clk) begin
            if (rst) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= w_next_ptr;
            end
        end

        always_ff @(posedge clk) begin
            if (w_any && w_sel_we) begin
                r_mem[w_sel_row] <= w_wr_word;
            end
        end

        // The row being read is the granted row; a bank never reads and
        // writes in the same cycle, so the old contents are the right data.
        assign w_bank_rdata[b] = r_mem[w_sel_row];

        assign o_dbg_ptr[PORT_BITS*b +: PORT_BITS] = r_ptr;
    end

    // A port targets exactly one bank, so OR-ing grants gives its ready.
    always_comb begin
        w_ready = '0;
        for (int b = 0; b < NBANK; b++) begin
            w_ready = w_ready | w_gnt[b];
        end
    end

    assign w_rd_acc      = w_ready & ~bus.req_we;
    assign bus.req_ready = w_ready;

    always_comb begin
        for (int p = 0; p < NPORT; p++) begin
            w_port_word[p] = w_bank_rdata[w_bank[p]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= w_rd_acc;
            for (int p = 0; p < NPORT; p++) begin
                if (w_rd_acc[p]) begin
                    r_rsp_rdata[DW*p +: DW] <= w_port_word[p][DW-1:0];
                end
            end
        end
    end

    // A read accepted just before reset must not surface while rst is high,
    // so the registered valid is qualified by rst.
    assign bus.rsp_valid = r_rsp_valid & {NPORT{~rst}};
    assign bus.rsp_rdata = r_rsp_rdata;

`ifdef BANKED_MEM_PARITY_EN
    logic [NPORT-1:0] r_rsp_perr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_perr <= '0;
        end else begin
            for (int p = 0; p < NPORT; p++) begin
                r_rsp_perr[p] <= w_rd_acc[p] &
                    (w_port_word[p][DW] != parity_f(w_port_word[p][DW-1:0]));
            end
        end
    end

    assign bus.rsp_perr = r_rsp_perr;
`else
    assign bus.rsp_perr = '0;
`endif

endmodule

// File: tb/tb_banked_mem.sv
// -----------------------------------------------------------------------------
// tb_banked_mem
// Self-checking bench for banked_mem. A behavioural model keeps a flat
// address-indexed memory, a round-robin pointer per bank and the expected
// registered responses; every cycle the DUT outputs are compared with it.
// Directed scenarios are followed by randomized traffic.
// Honours BANKED_MEM_PARITY_EN for the parity scenario.
// -----------------------------------------------------------------------------
module tb_banked_mem;
    import banked_mem_pkg::*;

    localparam int MEMSZ = 2 ** AW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    banked_mem_if bus ();
    logic [NBANK*PORT_BITS-1:0] dbg_ptr;

    banked_mem dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .o_dbg_ptr (dbg_ptr)
    );

    // ---------------- driver state ----------------
    logic [NPORT-1:0] d_valid = '0;
    logic [NPORT-1:0] d_we    = '0;
    logic [AW-1:0]    d_addr  [NPORT];
    logic [DW-1:0]    d_wdata [NPORT];

    always_comb begin
        bus.req_valid = d_valid;
        bus.req_we    = d_we;
        for (int p = 0; p < NPORT; p++) begin
            bus.req_addr[AW*p +: AW]  = d_addr[p];
            bus.req_wdata[DW*p +: DW] = d_wdata[p];
        end
    end

    // ---------------- reference model ----------------
    logic [DW-1:0]    m_mem     [MEMSZ];
    bit               m_corrupt [MEMSZ];
    int               m_ptr     [NBANK];
    logic [NPORT-1:0] m_rsp_valid = '0;
    logic [NPORT-1:0] m_perr      = '0;
    logic [DW-1:0]    m_rdata   [NPORT];
    logic [NPORT-1:0] m_acc       = '0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // For each bank, search ports in order ptr, ptr+1, ... and grant the first
    // one that has a request addressed to that bank.
    function automatic logic [NPORT-1:0] model_ready();
        logic [NPORT-1:0] r;
        int p;
        r = '0;
        if (rst) return r;
        for (int b = 0; b < NBANK; b++) begin
            for (int k = 0; k < NPORT; k++) begin
                p = (m_ptr[b] + k) % NPORT;
                if (d_valid[p] && ((int'(d_addr[p]) % NBANK) == b)) begin
                    r[p] = 1'b1;
                    break;
                end
            end
        end
        return r;
    endfunction

    // One clock: compare at the falling edge, then advance the model to the
    // state after the next rising edge. Returns 1 time unit after that edge.
    task automatic cycle();
        logic [NPORT-1:0]          exp_ready;
        logic [NPORT*DW-1:0]       exp_rdata;
        logic [NBANK*PORT_BITS-1:0] exp_ptr;
        logic [NPORT-1:0]          nv;
        logic [NPORT-1:0]          np;
        int a;
        @(negedge clk);
        exp_ready = model_ready();
        for (int p = 0; p < NPORT; p++) exp_rdata[DW*p +: DW] = m_rdata[p];
        for (int b = 0; b < NBANK; b++) exp_ptr[PORT_BITS*b +: PORT_BITS] = PORT_BITS'(m_ptr[b]);
        check("req_ready", bus.req_ready, exp_ready);
        check("rsp_valid", bus.rsp_valid, rst ? '0 : m_rsp_valid);
        check("rsp_rdata", bus.rsp_rdata, exp_rdata);
        check("rsp_perr",  bus.rsp_perr,  m_perr);
        check("rr_ptr",    dbg_ptr,       exp_ptr);
        if (rst) begin
            for (int b = 0; b < NBANK; b++) m_ptr[b] = 0;
            for (int p = 0; p < NPORT; p++) m_rdata[p] = '0;
            m_rsp_valid = '0;
            m_perr      = '0;
        end else begin
            nv = '0;
            np = '0;
            for (int p = 0; p < NPORT; p++) begin
                if (exp_ready[p]) begin
                    a = int'(d_addr[p]);
                    if (d_we[p]) begin
                        m_mem[a]     = d_wdata[p];
                        m_corrupt[a] = 1'b0;
                    end else begin
                        m_rdata[p] = m_mem[a] ^ DW'(m_corrupt[a]);
                        nv[p]      = 1'b1;
                        np[p]      = m_corrupt[a];
                    end
                    m_ptr[a % NBANK] = (p + 1) % NPORT;
                end
            end
            m_rsp_valid = nv;
            m_perr      = np;
        end
        m_acc = exp_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic we, input int addr, input logic [DW-1:0] wd);
        d_valid[p] = 1'b1;
        d_we[p]    = we;
        d_addr[p]  = AW'(addr);
        d_wdata[p] = wd;
    endtask

    task automatic idle_all();
        d_valid = '0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cnt [NPORT];
        int next_a;
        int guard;

        for (int p = 0; p < NPORT; p++) begin
            d_addr[p]  = '0;
            d_wdata[p] = '0;
            m_rdata[p] = '0;
        end
        for (int b = 0; b < NBANK; b++) m_ptr[b] = 0;
        for (int i = 0; i < MEMSZ; i++) begin
            m_mem[i]     = '0;
            m_corrupt[i] = 1'b0;
        end

        // Reset with requests present: nothing may be accepted.
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int p = 0; p < NPORT; p++) set_req(p, 1'b0, $urandom_range(0, MEMSZ - 1), '0);
        repeat (3) cycle();
        rst = 1'b0;
        idle_all();
        cycle();

        // Write 0x05 = 0xA5 on port 0, then read it back.
        set_req(0, 1'b1, 'h05, 8'hA5);
        #1 check("t1_wr_ready", bus.req_ready, 6'b000001);
        cycle();
        set_req(0, 1'b0, 'h05, '0);
        #1 check("t1_rd_ready", bus.req_ready, 6'b000001);
        cycle();
        idle_all();
        #1 check("t1_rsp_valid", bus.rsp_valid[0], 1'b1);
        check("t1_rdata", bus.rsp_rdata[7:0], 8'hA5);

        // Initialise every address through normal writes spread over all ports.
        next_a = 0;
        guard  = 0;
        m_acc  = '0;
        while ((next_a < MEMSZ || d_valid != '0) && guard < 1000) begin
            for (int p = 0; p < NPORT; p++) begin
                if (!d_valid[p] || m_acc[p]) begin
                    if (next_a < MEMSZ) begin
                        set_req(p, 1'b1, next_a, DW'($urandom));
                        next_a++;
                    end else begin
                        d_valid[p] = 1'b0;
                    end
                end
            end
            cycle();
            guard++;
        end
        check("fill_done", guard < 1000, 1'b1);

        // Ports 0..2 keep reading bank 1: one grant per cycle, shared evenly.
        idle_all();
        for (int p = 0; p < NPORT; p++) cnt[p] = 0;
        set_req(0, 1'b0, 1, '0);
        set_req(1, 1'b0, 5, '0);
        set_req(2, 1'b0, 9, '0);
        for (int i = 0; i < 6; i++) begin
            #1;
            check("t2_one_grant", $countones(bus.req_ready), 1);
            for (int p = 0; p < NPORT; p++) cnt[p] += int'(bus.req_ready[p]);
            cycle();
        end
        for (int p = 0; p < 3; p++) check("t2_share", cnt[p], 2);

        // Four ports, four different banks: all accepted together.
        idle_all();
        for (int p = 0; p < 4; p++) set_req(p, 1'b0, p, '0);
        #1 check("t3_ready", bus.req_ready, 6'b001111);
        cycle();
        idle_all();
        #1 check("t3_rsp_valid", bus.rsp_valid, 6'b001111);
        cycle();

        // Pointer wrap on bank 2: move ptr to 5, then ports 5 and 0 compete.
        set_req(4, 1'b0, 2, '0);
        #1 check("t4_pre_ready", bus.req_ready, 6'b010000);
        cycle();
        idle_all();
        #1 check("t4_ptr5", dbg_ptr[2*PORT_BITS +: PORT_BITS], 5);
        set_req(5, 1'b0, 2, '0);
        set_req(0, 1'b0, 6, '0);
        #1 check("t4_gnt5", bus.req_ready, 6'b100000);
        cycle();
        d_valid[5] = 1'b0;
        #1 check("t4_ptr0", dbg_ptr[2*PORT_BITS +: PORT_BITS], 0);
        check("t4_gnt0", bus.req_ready, 6'b000001);
        cycle();
        idle_all();
        #1 check("t4_ptr1", dbg_ptr[2*PORT_BITS +: PORT_BITS], 1);

        // Read accepted, then reset: no response; memory survives reset.
        set_req(1, 1'b0, 'h05, '0);
        cycle();
        idle_all();
        rst = 1'b1;
        #1 check("t5_no_rsp", bus.rsp_valid, 6'b000000);
        cycle();
        cycle();
        rst = 1'b0;
        set_req(1, 1'b0, 'h05, '0);
        cycle();
        idle_all();
        #1 check("t5_rsp_valid", bus.rsp_valid[1], 1'b1);
        check("t5_rdata", bus.rsp_rdata[DW*1 +: DW], m_mem[5]);

        // Randomized traffic; pending requests hold until accepted.
        m_acc = '0;
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < NPORT; p++) begin
                if (!d_valid[p] || m_acc[p]) begin
                    d_valid[p] = ($urandom_range(0, 3) != 0);
                    d_we[p]    = 1'($urandom_range(0, 1));
                    d_addr[p]  = AW'($urandom_range(0, MEMSZ - 1));
                    d_wdata[p] = DW'($urandom);
                end
            end
            cycle();
        end
        idle_all();
        cycle();

`ifdef BANKED_MEM_PARITY_EN
        // Flip one stored data bit behind the memory's back at 0x10 (bank 0, row 4).
        dut.gen_bank[0].r_mem[4][0] = ~dut.gen_bank[0].r_mem[4][0];
        m_corrupt['h10] = 1'b1;
        set_req(2, 1'b0, 'h10, '0);
        cycle();
        idle_all();
        #1 check("t6_perr", bus.rsp_perr[2], 1'b1);
        check("t6_valid", bus.rsp_valid[2], 1'b1);
        set_req(2, 1'b0, 'h14, '0);
        cycle();
        idle_all();
        #1 check("t6_clean", bus.rsp_perr[2], 1'b0);
        cycle();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
